// File: rtl/id_pkg.sv
// Shared types and constants for the identifier scanner: FSM states,
// character classes and the ASCII range bounds used for classification.
package id_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIdent,
    StOther,
    StEmit
  } state_e;

  typedef enum logic [1:0] {
    ClsLetter,
    ClsDigit,
    ClsDelim
  } char_class_e;

  localparam logic [7:0] AsciiLowA = 8'h61;
  localparam logic [7:0] AsciiLowZ = 8'h7a;
  localparam logic [7:0] AsciiUpA  = 8'h41;
  localparam logic [7:0] AsciiUpZ  = 8'h5a;
  localparam logic [7:0] AsciiDig0 = 8'h30;
  localparam logic [7:0] AsciiDig9 = 8'h39;

endpackage

// File: rtl/id_char_class.sv
// Purely combinational character classifier: LETTER, DIGIT or DELIM.
module id_char_class
  import id_pkg::*;
(
  input  logic [7:0] in_char,
  output logic [1:0] char_cls
);

  always_comb begin
    char_cls = ClsDelim;
    if ((in_char >= AsciiLowA && in_char <= AsciiLowZ) ||
        (in_char >= AsciiUpA && in_char <= AsciiUpZ)) begin
      char_cls = ClsLetter;
    end else if (in_char >= AsciiDig0 && in_char <= AsciiDig9) begin
      char_cls = ClsDigit;
    end
  end

endmodule

// File: rtl/id_scan_ctrl.sv
// Scans a character stream into tokens, reports each token's class and length,
// and counts the identifiers handed to the consumer.
module id_scan_ctrl
  import id_pkg::*;
#(
  parameter int unsigned LEN_W = 6,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       in_char,
  output logic             in_ready,
  output logic             tok_valid,
  input  logic             tok_ready,
  output logic             tok_is_id,
  output logic [LEN_W-1:0] tok_len,
  output logic             tok_ovf,
  output logic [CNT_W-1:0] id_count
);

  localparam logic [LEN_W-1:0] LenMax = '1;
  localparam logic [CNT_W-1:0] CntMax = '1;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovf_q, ovf_d;
  logic             load_res;
  logic             accept;
  logic [1:0]       cls_raw;
  char_class_e      cls;

  logic             tok_is_id_q;
  logic [LEN_W-1:0] tok_len_q;
  logic             tok_ovf_q;
  logic [CNT_W-1:0] id_count_q;

  id_char_class u_char_class (
    .in_char  (in_char),
    .char_cls (cls_raw)
  );

  assign cls    = char_class_e'(cls_raw);
  assign accept = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      len_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    ovf_d    = ovf_q;
    load_res = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept && cls != ClsDelim) begin
          state_d = (cls == ClsLetter) ? StIdent : StOther;
          len_d   = LEN_W'(1);
          ovf_d   = 1'b0;
        end
      end
      StIdent, StOther: begin
        if (accept) begin
          if (cls == ClsDelim) begin
            // Terminating delimiter is consumed but neither counted nor kept.
            state_d  = StEmit;
            load_res = 1'b1;
            len_d    = '0;
            ovf_d    = 1'b0;
          end else if (len_q == LenMax) begin
            ovf_d = 1'b1;
          end else begin
            len_d = len_q + LEN_W'(1);
          end
        end
      end
      StEmit: begin
        if (tok_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q != StEmit);
    tok_valid = (state_q == StEmit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tok_is_id_q <= 1'b0;
      tok_len_q   <= '0;
      tok_ovf_q   <= 1'b0;
    end else if (load_res) begin
      tok_is_id_q <= (state_q == StIdent);
      tok_len_q   <= len_q;
      tok_ovf_q   <= ovf_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_count_q <= '0;
    end else if (tok_valid && tok_ready && tok_is_id_q && id_count_q != CntMax) begin
      id_count_q <= id_count_q + CNT_W'(1);
    end
  end

  assign tok_is_id = tok_is_id_q;
  assign tok_len   = tok_len_q;
  assign tok_ovf   = tok_ovf_q;
  assign id_count  = id_count_q;

endmodule
